imem_ctrl: RTL and testbench
============================

Name: imem_ctrl

Overview:
- Access controller for the single-port instruction memory.
- Sequences a post-reset clear of every word, then shares the port between the CPU fetch stage (reads) and the program loader (writes, valid/ready handshake).
- Loader has fixed priority, bounded by an anti-starvation counter; fetch data is returned registered.
- Sits between the fetch stage/loader and the memory array (combinational read, synchronous write).

Parameters:
- INST_SIZE, 16, instruction word width.
- PC_SIZE, 13, address width.
- DEPTH, 24, number of implemented words (addresses 0..DEPTH-1).
- LOAD_BURST, 4, max consecutive loader grants while fetch is pending.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- fetch_req  in  1  CPU requests instruction at fetch_addr.
- fetch_addr  in  PC_SIZE  fetch address.
- fetch_instr  out  INST_SIZE  registered instruction.
- fetch_valid  out  1  fetch_instr holds data for the request granted last cycle.
- stall  out  1  fetch_req present but not granted this cycle (combinational).
- load_valid  in  1  loader has a word to write.
- load_addr  in  PC_SIZE  write address.
- load_data  in  INST_SIZE  write data.
- load_ready  out  1  loader word accepted this cycle when load_valid=1 (combinational).
- mem_addr  out  PC_SIZE  memory address.
- mem_wdata  out  INST_SIZE  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  INST_SIZE  memory combinational read data.
- boot_done  out  1  clear complete, normal operation.
- load_err  out  1  sticky: a loader write targeted address >= DEPTH.

Behaviour:
- Reset values when rst=0 at a clock edge:
  - state=CLEAR, clear_cnt=0, burst_cnt=0.
  - fetch_instr=0, fetch_valid=0, boot_done=0, load_err=0.
  - rst=0 mid-operation aborts any activity; the next cycle restarts CLEAR from address 0.
- States: CLEAR, RUN.
- CLEAR:
  - Drive mem_we=1, mem_addr=clear_cnt, mem_wdata=0; clear_cnt increments each cycle.
  - After writing DEPTH-1, go to RUN; boot_done=1 from the first RUN cycle.
  - CLEAR lasts exactly DEPTH cycles.
  - stall=fetch_req and load_ready=0 throughout.
- RUN arbitration, evaluated each cycle:
  - load_grant = load_valid && !(fetch_req && burst_cnt==LOAD_BURST).
  - fetch_grant = fetch_req && !load_grant.
  - load_ready=load_grant; stall=fetch_req && !fetch_grant.
- Load grant:
  - mem_we=1 only if load_addr < DEPTH; mem_addr=load_addr, mem_wdata=load_data.
  - If load_addr >= DEPTH, the word is still acknowledged, no write occurs, and load_err sets (sticky until reset).
- Fetch grant:
  - mem_we=0, mem_addr=fetch_addr.
  - At the edge, fetch_instr <= (fetch_addr < DEPTH) ? mem_rdata : 0 and fetch_valid <= 1. Latency is 1 cycle.
  - Cycles with no fetch grant set fetch_valid <= 0; fetch_instr holds its value.
- Idle (no grant): mem_we=0, mem_addr=fetch_addr.
- burst_cnt:
  - Increments on each load grant while fetch_req=1, saturating at LOAD_BURST.
  - Clears to 0 on any fetch grant or any cycle with fetch_req=0.
  - Result: at most LOAD_BURST consecutive stalls caused by the loader.
- Same-address load write and fetch cannot occur in one cycle; the loader wins, and a fetch granted later reads the new data.
- Widths: clear_cnt and burst_cnt are sized to hold DEPTH and LOAD_BURST. Address compares are unsigned, PC_SIZE bits.

Test Plan:
- Reset then release: held rst=0 for 2 cycles -> mem_we=1 with addrs 0..23 and wdata=0 for 24 cycles, boot_done=1 on cycle 25, stall=1 if fetch_req held during CLEAR.
- Fetch after boot: memory word 5=16'hA5C3, fetch_req=1 with addr 5 -> stall=0, next cycle fetch_valid=1 and fetch_instr=16'hA5C3; addr 30 -> fetch_instr=0, fetch_valid=1.
- Load then fetch: load_valid with addr 3, data 16'h1234 accepted (load_ready=1, mem_we=1), then fetch addr 3 -> fetch_instr=16'h1234.
- Contention: fetch_req and load_valid held high continuously -> pattern of 4 load grants (stall=1), 1 fetch grant, repeating; burst_cnt never exceeds 4.
- Out-of-range load: load_addr=24 -> load_ready=1, mem_we=0, load_err=1 and stays 1 until rst=0.
- Reset mid-load: rst=0 during a load burst -> next cycles restart CLEAR at address 0, load_err=0, fetch_valid=0, boot_done=0.

Source files
------------

// File: rtl/imem_ctrl_if.sv
// Bundle of fetch, loader and memory-array signals around the instruction memory controller.
// slave is the controller's view; master is the view of the surrounding fetch/loader/memory.
interface imem_ctrl_if #(
  parameter int INST_SIZE = 16,
  parameter int PC_SIZE   = 13
);
  logic                 fetch_req;
  logic [PC_SIZE-1:0]   fetch_addr;
  logic [INST_SIZE-1:0] fetch_instr;
  logic                 fetch_valid;
  logic                 stall;
  logic                 load_valid;
  logic [PC_SIZE-1:0]   load_addr;
  logic [INST_SIZE-1:0] load_data;
  logic                 load_ready;
  logic [PC_SIZE-1:0]   mem_addr;
  logic [INST_SIZE-1:0] mem_wdata;
  logic                 mem_we;
  logic [INST_SIZE-1:0] mem_rdata;
  logic                 boot_done;
  logic                 load_err;

  modport slave (
    input  fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
    output fetch_instr, fetch_valid, stall, load_ready, mem_addr, mem_wdata, mem_we,
           boot_done, load_err
  );

  modport master (
    output fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
    input  fetch_instr, fetch_valid, stall, load_ready, mem_addr, mem_wdata, mem_we,
           boot_done, load_err
  );
endinterface

// File: rtl/imem_ctrl.sv
// Single-port instruction memory controller: post-reset clear, then loader-priority
// arbitration against CPU fetch with a bounded loader burst and registered fetch data.
//
// state | meaning
// CLEAR | writing zero to every word, one per cycle, fetch and loader held off
// RUN   | normal operation, loader wins unless it has starved fetch LOAD_BURST times
module imem_ctrl #(
  parameter int INST_SIZE  = 16,
  parameter int PC_SIZE    = 13,
  parameter int DEPTH      = 24,
  parameter int LOAD_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  imem_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(LOAD_BURST + 1);
  localparam logic [PC_SIZE-1:0] DEPTH_A   = PC_SIZE'(DEPTH);
  localparam logic [CW-1:0]      CLR_LAST  = CW'(DEPTH - 1);
  localparam logic [BW-1:0]      BURST_MAX = BW'(LOAD_BURST);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t         state;
  logic [CW-1:0]  clear_cnt;
  logic [BW-1:0]  burst_cnt;
  logic           load_grant;
  logic           fetch_grant;
  logic           load_in_range;
  logic           fetch_in_range;
  logic           burst_full;

  always_comb begin
    load_in_range  = bus.load_addr < DEPTH_A;
    fetch_in_range = bus.fetch_addr < DEPTH_A;
    burst_full     = burst_cnt == BURST_MAX;
    load_grant     = 1'b0;
    fetch_grant    = 1'b0;
    bus.load_ready = 1'b0;
    bus.stall      = bus.fetch_req;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = bus.fetch_addr;
    bus.mem_wdata  = '0;
    if (state == CLEAR) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = PC_SIZE'(clear_cnt);
    end else begin
      load_grant     = bus.load_valid && !(bus.fetch_req && burst_full);
      fetch_grant    = bus.fetch_req && !load_grant;
      bus.load_ready = load_grant;
      bus.stall      = bus.fetch_req && !fetch_grant;
      if (load_grant) begin
        // out-of-range loader words are acknowledged but never reach the array
        bus.mem_we    = load_in_range;
        bus.mem_addr  = bus.load_addr;
        bus.mem_wdata = bus.load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= CLEAR;
      clear_cnt       <= '0;
      burst_cnt       <= '0;
      bus.fetch_instr <= '0;
      bus.fetch_valid <= 1'b0;
      bus.boot_done   <= 1'b0;
      bus.load_err    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          bus.fetch_valid <= 1'b0;
          clear_cnt       <= clear_cnt + 1'b1;
          if (clear_cnt == CLR_LAST) begin
            state         <= RUN;
            bus.boot_done <= 1'b1;
          end
        end
        RUN: begin
          bus.fetch_valid <= fetch_grant;
          if (fetch_grant)
            bus.fetch_instr <= fetch_in_range ? bus.mem_rdata : '0;
          if (load_grant && !load_in_range)
            bus.load_err <= 1'b1;
          if (!bus.fetch_req || fetch_grant)
            burst_cnt <= '0;
          else if (load_grant && !burst_full)
            burst_cnt <= burst_cnt + 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: directed scenarios plus random traffic, checked every cycle
// against a word-level model of the memory contents and arbitration rules.
module tb_imem_ctrl;
  localparam int INST_SIZE  = 16;
  localparam int PC_SIZE    = 13;
  localparam int DEPTH      = 24;
  localparam int LOAD_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_ctrl_if #(.INST_SIZE(INST_SIZE), .PC_SIZE(PC_SIZE)) bus ();

  imem_ctrl #(
    .INST_SIZE(INST_SIZE), .PC_SIZE(PC_SIZE), .DEPTH(DEPTH), .LOAD_BURST(LOAD_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // memory array the controller drives; unimplemented addresses read as junk
  logic [INST_SIZE-1:0] env_mem [32];
  always_ff @(posedge clk)
    if (bus.mem_we && bus.mem_addr < PC_SIZE'(DEPTH))
      env_mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
  always_comb begin
    bus.mem_rdata = 16'hDEAD;
    if (bus.mem_addr < PC_SIZE'(DEPTH)) bus.mem_rdata = env_mem[bus.mem_addr[4:0]];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // word-level reference model
  logic [INST_SIZE-1:0] ref_mem [DEPTH];
  bit   model_ok = 0;
  bit   booted;
  int   clear_idx;
  int   streak;
  bit   exp_valid, exp_err;
  logic [INST_SIZE-1:0] exp_instr;
  int   stall_run = 0;

  always @(negedge clk) begin
    bit lw, fw, e_we, e_ready, e_stall;
    int e_addr;
    logic [INST_SIZE-1:0] e_wdata;
    int la, fa;
    la = int'(bus.load_addr);
    fa = int'(bus.fetch_addr);
    lw = 0; fw = 0;
    if (booted) begin
      lw = bus.load_valid && !(bus.fetch_req && streak >= LOAD_BURST);
      fw = bus.fetch_req && !lw;
    end
    if (!booted) begin
      e_we = 1; e_addr = clear_idx; e_wdata = '0; e_stall = bus.fetch_req; e_ready = 0;
    end else begin
      e_ready = lw;
      e_stall = bus.fetch_req && !fw;
      e_we    = lw && la < DEPTH;
      e_addr  = lw ? la : fa;
      e_wdata = bus.load_data;
    end
    if (model_ok) begin
      check("boot_done", bus.boot_done, booted);
      check("load_err", bus.load_err, exp_err);
      check("fetch_valid", bus.fetch_valid, exp_valid);
      check("fetch_instr", bus.fetch_instr, exp_instr);
      check("stall", bus.stall, e_stall);
      check("load_ready", bus.load_ready, e_ready);
      check("mem_we", bus.mem_we, e_we);
      check("mem_addr", bus.mem_addr, e_addr);
      if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
      if (bus.boot_done && bus.stall) stall_run++; else stall_run = 0;
      check("stall_bound", (stall_run > LOAD_BURST), 0);
    end
    if (!rst) begin
      model_ok = 1; booted = 0; clear_idx = 0; streak = 0;
      exp_valid = 0; exp_err = 0; exp_instr = '0;
    end else if (model_ok) begin
      if (!booted) begin
        ref_mem[clear_idx] = '0;
        clear_idx++;
        if (clear_idx == DEPTH) booted = 1;
        exp_valid = 0;
      end else begin
        if (lw) begin
          if (la < DEPTH) ref_mem[la] = bus.load_data;
          else exp_err = 1;
        end
        if (!bus.fetch_req || fw) streak = 0;
        else if (lw && streak < LOAD_BURST) streak++;
        exp_valid = fw;
        if (fw) exp_instr = (fa < DEPTH) ? ref_mem[fa] : '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.fetch_req = 0; bus.fetch_addr = '0;
    bus.load_valid = 0; bus.load_addr = '0; bus.load_data = '0;
    rst = 0;
    step(); step();
    rst = 1; bus.fetch_req = 1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("clr_we", bus.mem_we, 1);
      check("clr_addr", bus.mem_addr, i);
      check("clr_wdata", bus.mem_wdata, 0);
      check("clr_stall", bus.stall, 1);
      check("clr_boot", bus.boot_done, 0);
      step();
    end
    @(negedge clk);
    check("boot_after_clear", bus.boot_done, 1);

    step(); bus.fetch_req = 0;
    bus.load_valid = 1; bus.load_addr = 13'd5; bus.load_data = 16'hA5C3;
    @(negedge clk);
    check("ld5_ready", bus.load_ready, 1);
    check("ld5_we", bus.mem_we, 1);
    step(); bus.load_valid = 0; bus.fetch_req = 1; bus.fetch_addr = 13'd5;
    @(negedge clk);
    check("f5_stall", bus.stall, 0);
    step(); bus.fetch_addr = 13'd30;
    @(negedge clk);
    check("f5_valid", bus.fetch_valid, 1);
    check("f5_instr", bus.fetch_instr, 32'hA5C3);
    step(); bus.fetch_req = 0;
    @(negedge clk);
    check("f30_valid", bus.fetch_valid, 1);
    check("f30_instr", bus.fetch_instr, 0);

    step(); bus.load_valid = 1; bus.load_addr = 13'd3; bus.load_data = 16'h1234;
    @(negedge clk);
    check("ld3_ready", bus.load_ready, 1);
    step(); bus.load_valid = 0; bus.fetch_req = 1; bus.fetch_addr = 13'd3;
    step(); bus.fetch_req = 0;
    @(negedge clk);
    check("f3_instr", bus.fetch_instr, 32'h1234);

    step(); bus.load_valid = 1; bus.load_addr = 13'd24; bus.load_data = 16'hBEEF;
    @(negedge clk);
    check("oor_ready", bus.load_ready, 1);
    check("oor_we", bus.mem_we, 0);
    check("oor_err_before", bus.load_err, 0);
    step(); bus.load_valid = 0;
    @(negedge clk);
    check("oor_err_set", bus.load_err, 1);
    step(); step(); step();
    @(negedge clk);
    check("oor_err_sticky", bus.load_err, 1);

    step(); bus.fetch_req = 1; bus.fetch_addr = 13'd5;
    bus.load_valid = 1; bus.load_addr = 13'd7; bus.load_data = 16'h0777;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("contend_stall", bus.stall, (i % 5) != 4);
      step();
    end
    bus.fetch_req = 0; bus.load_valid = 0;

    for (int n = 0; n < 3000; n++) begin
      step();
      rst = ($urandom_range(0, 299) != 0);
      bus.fetch_req  = $urandom_range(0, 3) != 0;
      bus.fetch_addr = ($urandom_range(0, 19) == 0) ? PC_SIZE'($urandom_range(24, 8191))
                                                    : PC_SIZE'($urandom_range(0, 31));
      bus.load_valid = $urandom_range(0, 2) != 0;
      bus.load_addr  = ($urandom_range(0, 19) == 0) ? PC_SIZE'($urandom_range(24, 8191))
                                                    : PC_SIZE'($urandom_range(0, 28));
      bus.load_data  = INST_SIZE'($urandom);
    end

    step(); rst = 1; bus.fetch_req = 0; bus.load_valid = 0;
    for (int k = 0; k < 40 && !bus.boot_done; k++) step();
    check("boot_wait", bus.boot_done, 1);

    bus.load_valid = 1; bus.load_addr = 13'd30; bus.fetch_req = 1; bus.fetch_addr = 13'd2;
    step(); bus.load_addr = 13'd9;
    @(negedge clk);
    check("midload_err", bus.load_err, 1);
    step(); rst = 0;
    step(); rst = 1;
    @(negedge clk);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_we", bus.mem_we, 1);
    check("rst_err", bus.load_err, 0);
    check("rst_valid", bus.fetch_valid, 0);
    check("rst_boot", bus.boot_done, 0);
    check("rst_ready", bus.load_ready, 0);
    step(); step();
    @(negedge clk);
    check("rst_addr2", bus.mem_addr, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
